id_ex_stage: RTL

- Parametrised decode stage with registered ID/EX pipeline register for the RV32I core.
- Decodes the instruction from IF/ID and reads the regfile.
- Forwards from N older stages, excluding x0.
- Detects load-use hazards with an interlock FSM.
- Honours downstream stall and branch flush.
- Adds over the previous decode stage: LOAD/STORE decode, illegal-instruction flag, and registered outputs with a valid bit.

---
 rtl/id_ex_stage_pkg.sv | 62 ++++++
 rtl/id_decoder.sv | 153 +++++++++++++++
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared codes for the RV32I decode stage
// Purpose: opcode/funct codes, EX operation and result-select codes,
//          memory-op encoding and the interlock state type.
// Ports: none (package).
package id_ex_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [7:0] EX_NOP_OP  = 8'h00;
    localparam logic [7:0] EX_ADD_OP  = 8'h01;
    localparam logic [7:0] EX_SUB_OP  = 8'h02;
    localparam logic [7:0] EX_SLT_OP  = 8'h03;
    localparam logic [7:0] EX_SLTU_OP = 8'h04;
    localparam logic [7:0] EX_XOR_OP  = 8'h05;
    localparam logic [7:0] EX_OR_OP   = 8'h06;
    localparam logic [7:0] EX_AND_OP  = 8'h07;
    localparam logic [7:0] EX_SLL_OP  = 8'h08;
    localparam logic [7:0] EX_SRL_OP  = 8'h09;
    localparam logic [7:0] EX_SRA_OP  = 8'h0A;
    localparam logic [7:0] EX_LUI_OP  = 8'h0B;
    localparam logic [7:0] EX_JAL_OP  = 8'h0C;
    localparam logic [7:0] EX_JALR_OP = 8'h0D;
    // Branch ops carry funct3 in the low bits so EX can pick the comparison.
    localparam logic [7:0] EX_BR_OP   = 8'h10;

    localparam logic [2:0] EX_RES_NOP     = 3'd0;
    localparam logic [2:0] EX_RES_ARITH   = 3'd1;
    localparam logic [2:0] EX_RES_LOGIC   = 3'd2;
    localparam logic [2:0] EX_RES_SHIFT   = 3'd3;
    localparam logic [2:0] EX_RES_COMPARE = 3'd4;
    localparam logic [2:0] EX_RES_JUMP    = 3'd5;
    localparam logic [2:0] EX_RES_BRANCH  = 3'd6;
    localparam logic [2:0] EX_RES_MEM     = 3'd7;

    localparam logic [3:0] MEM_OP_NONE = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_INTERLOCK = 1'b1
    } state_e;

endpackage

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational RV32I instruction decoder
// Purpose: inst -> alu op/select, read enables/addresses, immediate,
//          writeback enable/address, memory op and illegal flag.
// Ports: inst_i in; aluop_o, alusel_o, r1/r2_enable_o, r1/r2_addr_o,
//        imm_o, w_enable_o, w_addr_o, mem_op_o, use_pc_o, illegal_o out.
module id_decoder
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic [31:0]         inst_i,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic                r1_enable_o,
    output logic                r2_enable_o,
    output logic [4:0]          r1_addr_o,
    output logic [4:0]          r2_addr_o,
    output logic [XLEN-1:0]     imm_o,
    output logic                w_enable_o,
    output logic [4:0]          w_addr_o,
    output logic [3:0]          mem_op_o,
    output logic                use_pc_o,
    output logic                illegal_o
);

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [7:0] op8;
    logic [2:0] sel;
    logic       bad;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];

    assign imm_i  = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'h000};
    assign imm_j  = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_sh = {{(XLEN-5){1'b0}}, inst_i[24:20]};

    assign r1_addr_o = inst_i[19:15];
    assign r2_addr_o = inst_i[24:20];
    assign aluop_o   = ALUOP_W'(op8);
    assign alusel_o  = ALUSEL_W'(sel);
    assign w_addr_o  = w_enable_o ? inst_i[11:7] : 5'd0;

    always_comb begin
        op8         = EX_NOP_OP;
        sel         = EX_RES_NOP;
        r1_enable_o = 1'b0;
        r2_enable_o = 1'b0;
        imm_o       = '0;
        w_enable_o  = 1'b0;
        mem_op_o    = MEM_OP_NONE;
        use_pc_o    = 1'b0;
        bad         = 1'b0;

        case (opc)
            OPC_LUI: begin
                op8 = EX_LUI_OP; sel = EX_RES_ARITH; w_enable_o = 1'b1; imm_o = imm_u;
            end
            OPC_AUIPC: begin
                op8 = EX_ADD_OP; sel = EX_RES_ARITH; w_enable_o = 1'b1; imm_o = imm_u;
                use_pc_o = 1'b1;
            end
            OPC_JAL: begin
                op8 = EX_JAL_OP; sel = EX_RES_JUMP; w_enable_o = 1'b1; imm_o = imm_j;
            end
            OPC_JALR: begin
                op8 = EX_JALR_OP; sel = EX_RES_JUMP; w_enable_o = 1'b1; imm_o = imm_i;
                r1_enable_o = 1'b1;
                bad = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                op8 = EX_BR_OP | {5'd0, f3}; sel = EX_RES_BRANCH; imm_o = imm_b;
                r1_enable_o = 1'b1; r2_enable_o = 1'b1;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                op8 = EX_ADD_OP; sel = EX_RES_MEM; w_enable_o = 1'b1; imm_o = imm_i;
                r1_enable_o = 1'b1; mem_op_o = {1'b0, f3};
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                op8 = EX_ADD_OP; sel = EX_RES_MEM; imm_o = imm_s;
                r1_enable_o = 1'b1; r2_enable_o = 1'b1; mem_op_o = {1'b1, f3};
                bad = (f3[2] == 1'b1) || (f3 == 3'b011);
            end
            OPC_OP_IMM: begin
                r1_enable_o = 1'b1; w_enable_o = 1'b1; imm_o = imm_i;
                case (f3)
                    F3_ADD:  begin op8 = EX_ADD_OP;  sel = EX_RES_ARITH;   end
                    F3_SLT:  begin op8 = EX_SLT_OP;  sel = EX_RES_COMPARE; end
                    F3_SLTU: begin op8 = EX_SLTU_OP; sel = EX_RES_COMPARE; end
                    F3_XOR:  begin op8 = EX_XOR_OP;  sel = EX_RES_LOGIC;   end
                    F3_OR:   begin op8 = EX_OR_OP;   sel = EX_RES_LOGIC;   end
                    F3_AND:  begin op8 = EX_AND_OP;  sel = EX_RES_LOGIC;   end
                    F3_SLL: begin
                        op8 = EX_SLL_OP; sel = EX_RES_SHIFT; imm_o = imm_sh;
                        bad = (f7 != F7_BASE);
                    end
                    default: begin
                        op8 = (f7 == F7_ALT) ? EX_SRA_OP : EX_SRL_OP;
                        sel = EX_RES_SHIFT; imm_o = imm_sh;
                        bad = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                r1_enable_o = 1'b1; r2_enable_o = 1'b1; w_enable_o = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  begin op8 = EX_ADD_OP;  sel = EX_RES_ARITH;   end
                        F3_SLL:  begin op8 = EX_SLL_OP;  sel = EX_RES_SHIFT;   end
                        F3_SLT:  begin op8 = EX_SLT_OP;  sel = EX_RES_COMPARE; end
                        F3_SLTU: begin op8 = EX_SLTU_OP; sel = EX_RES_COMPARE; end
                        F3_XOR:  begin op8 = EX_XOR_OP;  sel = EX_RES_LOGIC;   end
                        F3_SR:   begin op8 = EX_SRL_OP;  sel = EX_RES_SHIFT;   end
                        F3_OR:   begin op8 = EX_OR_OP;   sel = EX_RES_LOGIC;   end
                        default: begin op8 = EX_AND_OP;  sel = EX_RES_LOGIC;   end
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    op8 = EX_SUB_OP; sel = EX_RES_ARITH;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    op8 = EX_SRA_OP; sel = EX_RES_SHIFT;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        // Anything unrecognised collapses to a NOP that reads and writes nothing.
        if (bad) begin
            op8         = EX_NOP_OP;
            sel         = EX_RES_NOP;
            r1_enable_o = 1'b0;
            r2_enable_o = 1'b0;
            imm_o       = '0;
            w_enable_o  = 1'b0;
            mem_op_o    = MEM_OP_NONE;
            use_pc_o    = 1'b0;
        end
    end

    assign illegal_o = bad;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode stage with forwarding, load-use interlock and ID/EX register
// Purpose: decode IF/ID, select operands (imm / x0 / forward / regfile),
//          insert bubbles on load-use hazards, register results for EX.
// Ports: clk, rst; if_valid_i, pc_i, inst_i; regfile r*_data_i / r*_enable_o / r*_addr_o;
//        fwd_* forwarding sources; stall_i, flush_i, stall_req_o; ex_* registered outputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int FWD_PORTS       = 2,
    parameter int LU_STALL_CYCLES = 1,
    parameter int ALUOP_W         = 8,
    parameter int ALUSEL_W        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_valid_i,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    input  logic [XLEN-1:0]           r1_data_i,
    input  logic [XLEN-1:0]           r2_data_i,
    output logic                      r1_enable_o,
    output logic                      r2_enable_o,
    output logic [4:0]                r1_addr_o,
    output logic [4:0]                r2_addr_o,
    input  logic [FWD_PORTS-1:0]      fwd_w_enable_i,
    input  logic [5*FWD_PORTS-1:0]    fwd_w_addr_i,
    input  logic [XLEN*FWD_PORTS-1:0] fwd_w_data_i,
    input  logic [FWD_PORTS-1:0]      fwd_is_load_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      stall_req_o,
    output logic                      ex_valid_o,
    output logic [31:0]               ex_pc_o,
    output logic [ALUOP_W-1:0]        ex_aluop_o,
    output logic [ALUSEL_W-1:0]       ex_alusel_o,
    output logic [XLEN-1:0]           ex_r1_data_o,
    output logic [XLEN-1:0]           ex_r2_data_o,
    output logic [XLEN-1:0]           ex_imm_o,
    output logic                      ex_w_enable_o,
    output logic [4:0]                ex_w_addr_o,
    output logic [3:0]                ex_mem_op_o,
    output logic                      ex_illegal_o
);

    logic [ALUOP_W-1:0]  d_aluop;
    logic [ALUSEL_W-1:0] d_alusel;
    logic [XLEN-1:0]     d_imm;
    logic                d_w_enable, d_use_pc, d_illegal;
    logic [4:0]          d_w_addr;
    logic [3:0]          d_mem_op;

    id_decoder #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) u_dec (
        .inst_i      (inst_i),
        .aluop_o     (d_aluop),
        .alusel_o    (d_alusel),
        .r1_enable_o (r1_enable_o),
        .r2_enable_o (r2_enable_o),
        .r1_addr_o   (r1_addr_o),
        .r2_addr_o   (r2_addr_o),
        .imm_o       (d_imm),
        .w_enable_o  (d_w_enable),
        .w_addr_o    (d_w_addr),
        .mem_op_o    (d_mem_op),
        .use_pc_o    (d_use_pc),
        .illegal_o   (d_illegal)
    );

    state_e    state_q;
    logic [2:0] cnt_q;

    logic            hit1, hit2, ld1, ld2, hazard, issue;
    logic [XLEN-1:0] fwd1, fwd2, op1, op2;

    // Scan oldest to youngest so the lowest-index match is the one that sticks.
    always_comb begin
        hit1 = 1'b0; ld1 = 1'b0; fwd1 = '0;
        hit2 = 1'b0; ld2 = 1'b0; fwd2 = '0;
        for (int k = FWD_PORTS - 1; k >= 0; k--) begin
            if (fwd_w_enable_i[k] && fwd_w_addr_i[5*k +: 5] == r1_addr_o) begin
                hit1 = 1'b1; ld1 = fwd_is_load_i[k]; fwd1 = fwd_w_data_i[XLEN*k +: XLEN];
            end
            if (fwd_w_enable_i[k] && fwd_w_addr_i[5*k +: 5] == r2_addr_o) begin
                hit2 = 1'b1; ld2 = fwd_is_load_i[k]; fwd2 = fwd_w_data_i[XLEN*k +: XLEN];
            end
        end
    end

    always_comb begin
        if (d_use_pc)                op1 = XLEN'(pc_i);
        else if (!r1_enable_o)       op1 = d_imm;
        else if (r1_addr_o == 5'd0)  op1 = '0;
        else if (hit1)               op1 = fwd1;
        else                         op1 = r1_data_i;

        if (!r2_enable_o)            op2 = d_imm;
        else if (r2_addr_o == 5'd0)  op2 = '0;
        else if (hit2)               op2 = fwd2;
        else                         op2 = r2_data_i;
    end

    // x0 reads never wait on a load, whatever the sources claim to write.
    assign hazard = if_valid_i &&
                    ((r1_enable_o && r1_addr_o != 5'd0 && hit1 && ld1) ||
                     (r2_enable_o && r2_addr_o != 5'd0 && hit2 && ld2));

    assign stall_req_o = !flush_i &&
                         (stall_i || state_q == ST_INTERLOCK || (state_q == ST_RUN && hazard));

    // A flush or any non-issuing cycle yields a bubble through the same path.
    assign issue = !flush_i && state_q == ST_RUN && if_valid_i && !hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else if (flush_i) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else if (!stall_i) begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        cnt_q <= 3'(LU_STALL_CYCLES - 1);
                        if (LU_STALL_CYCLES > 1) state_q <= ST_INTERLOCK;
                    end
                end
                default: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_aluop_o    <= '0;
            ex_alusel_o   <= '0;
            ex_r1_data_o  <= '0;
            ex_r2_data_o  <= '0;
            ex_imm_o      <= '0;
            ex_w_enable_o <= 1'b0;
            ex_w_addr_o   <= '0;
            ex_mem_op_o   <= MEM_OP_NONE;
            ex_illegal_o  <= 1'b0;
        end else if (flush_i || !stall_i) begin
            ex_valid_o    <= issue;
            ex_pc_o       <= issue ? pc_i       : '0;
            ex_aluop_o    <= issue ? d_aluop    : '0;
            ex_alusel_o   <= issue ? d_alusel   : '0;
            ex_r1_data_o  <= issue ? op1        : '0;
            ex_r2_data_o  <= issue ? op2        : '0;
            ex_imm_o      <= issue ? d_imm      : '0;
            ex_w_enable_o <= issue && d_w_enable;
            ex_w_addr_o   <= issue ? d_w_addr   : '0;
            ex_mem_op_o   <= issue ? d_mem_op   : MEM_OP_NONE;
            ex_illegal_o  <= issue && d_illegal;
        end
    end

endmodule
